rs_syndrome_calc: RTL and testbench

Syndrome stage of the RS(15,11) decoder over GF(16): accepts one received codeword as 15 serial 4-bit symbols and evaluates it at α¹…α⁴ with four parallel Horner accumulators. Sits directly upstream of the Euclid division section. Its four registered syndromes drive that block's `syndrome0..3` inputs. A one-cycle `SYN_VALID` pulse tells the decoder controller to load them.

---
 rtl/rs_pkg.sv | 38 +++
 rtl/rs_syndrome_calc_if.sv | 29 ++
 rtl/rs_syndrome_calc_syn_cell.sv | 26 ++
 rtl/rs_syndrome_calc.sv | 109 ++++++++++
 tb/tb_rs_syndrome_calc.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/rs_pkg.sv
// Shared GF(16) definitions for the RS(15,11) decoder: field constants,
// alpha-power table, constant-multiplier helper and syndrome-stage states.
package rs_pkg;

    localparam int unsigned GF_W    = 4;
    localparam int unsigned RS_N    = 15;
    localparam int unsigned RS_K    = 11;
    localparam int unsigned RS_NSYN = 4;

    // x^4 + x + 1 with the x^4 term implied
    localparam logic [GF_W-1:0] PRIM_POLY = 4'b0011;

    localparam logic [GF_W-1:0] ALPHA_POW [RS_N] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
        4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
    };

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    // Shift-and-add GF multiply; with a constant operand it reduces to XORs.
    function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a,
                                               input logic [GF_W-1:0] b);
        logic [GF_W-1:0] prod;
        logic [GF_W-1:0] x;
        prod = '0;
        x    = a;
        for (int unsigned i = 0; i < GF_W; i++) begin
            if (b[i]) prod = prod ^ x;
            x = {x[GF_W-2:0], 1'b0} ^ (x[GF_W-1] ? PRIM_POLY : '0);
        end
        return prod;
    endfunction

endpackage

// File: rtl/rs_syndrome_calc_if.sv
// Symbol-in / syndrome-out bundle between the received-symbol source and
// the syndrome stage.
interface rs_syndrome_calc_if;
    import rs_pkg::*;

    logic [GF_W-1:0] DIN;
    logic            DIN_VALID;
    logic            SOF;
    logic [GF_W-1:0] syndrome0;
    logic [GF_W-1:0] syndrome1;
    logic [GF_W-1:0] syndrome2;
    logic [GF_W-1:0] syndrome3;
    logic            SYN_VALID;
    logic            ERR_FLAG;
    logic            BUSY;

    modport master (
        output DIN, DIN_VALID, SOF,
        input  syndrome0, syndrome1, syndrome2, syndrome3,
        input  SYN_VALID, ERR_FLAG, BUSY
    );

    modport slave (
        input  DIN, DIN_VALID, SOF,
        output syndrome0, syndrome1, syndrome2, syndrome3,
        output SYN_VALID, ERR_FLAG, BUSY
    );

endinterface

// File: rtl/rs_syndrome_calc_syn_cell.sv
// One Horner cell: acc <- acc * alpha^ROOT_POW + din, with a load path for
// the first symbol. fb is the value the accumulator would take on enable.
module syn_cell
    import rs_pkg::*;
#(
    parameter int unsigned ROOT_POW = 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            load,
    input  logic            en,
    input  logic [GF_W-1:0] din,
    output logic [GF_W-1:0] fb
);

    logic [GF_W-1:0] acc;

    assign fb = gf_mul(acc, ALPHA_POW[ROOT_POW]) ^ din;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)     acc <= '0;
        else if (load) acc <= din;
        else if (en)   acc <= fb;
    end

endmodule

// File: rtl/rs_syndrome_calc.sv
// RS(15,11) syndrome stage: four parallel Horner cells evaluated at alpha^1..4.
// Define RS_SYN_ERR_FLAG_EN to register ERR_FLAG = |syndromes; otherwise it is 0.
module rs_syndrome_calc
    import rs_pkg::*;
(
    input logic               CLK,
    input logic               RESET,
    rs_syndrome_calc_if.slave bus
);

    state_t          state, state_d;
    logic [3:0]      cnt, cnt_d;
    logic            load, en, capture;
    logic [GF_W-1:0] fb    [RS_NSYN];
    logic [GF_W-1:0] syn_q [RS_NSYN];
    logic            syn_valid_q;

    genvar g;
    generate
        for (g = 0; g < RS_NSYN; g++) begin : g_cell
            syn_cell #(.ROOT_POW(g + 1)) u_cell (
                .CLK   (CLK),
                .RESET (RESET),
                .load  (load),
                .en    (en),
                .din   (bus.DIN),
                .fb    (fb[g])
            );
        end
    endgenerate

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // SOF in ACC restarts the codeword without touching the output registers.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        load    = 1'b0;
        en      = 1'b0;
        capture = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.DIN_VALID && bus.SOF) begin
                    load    = 1'b1;
                    cnt_d   = 4'd1;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (bus.DIN_VALID && bus.SOF) begin
                    load  = 1'b1;
                    cnt_d = 4'd1;
                end else if (bus.DIN_VALID) begin
                    en = 1'b1;
                    if (cnt == 4'(RS_N - 1)) begin
                        capture = 1'b1;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            syn_valid_q <= 1'b0;
            for (int unsigned j = 0; j < RS_NSYN; j++) syn_q[j] <= '0;
        end else begin
            syn_valid_q <= capture;
            if (capture) begin
                for (int unsigned j = 0; j < RS_NSYN; j++) syn_q[j] <= fb[j];
            end
        end
    end

`ifdef RS_SYN_ERR_FLAG_EN
    logic err_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)        err_q <= 1'b0;
        else if (capture) err_q <= |(fb[0] | fb[1] | fb[2] | fb[3]);
    end

    assign bus.ERR_FLAG = err_q;
`else
    assign bus.ERR_FLAG = 1'b0;
`endif

    assign bus.syndrome0 = syn_q[0];
    assign bus.syndrome1 = syn_q[1];
    assign bus.syndrome2 = syn_q[2];
    assign bus.syndrome3 = syn_q[3];
    assign bus.SYN_VALID = syn_valid_q;
    assign bus.BUSY      = (state == ACC);

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Self-checking bench for rs_syndrome_calc: fixed vector table, hand-written
// corner sequences and random codewords against a log/antilog GF(16) model.
module tb_rs_syndrome_calc;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rs_syndrome_calc_if bus();

    rs_syndrome_calc dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    typedef struct {
        string            name;
        logic [14:0][3:0] cw;    // cw[0] is r14, sent first
        logic [15:0]      syn;   // {S3,S2,S1,S0}
    } vec_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          last_pulse = 0;
    int          exp_t [15];
    int          log_t [16];
    logic [15:0] cur_syn;
    vec_t        tbl [5];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 4'h0 || b == 4'h0) return 4'h0;
        return 4'(exp_t[(log_t[a] + log_t[b]) % 15]);
    endfunction

    // r(x) evaluated directly at alpha^(j+1), coefficient of x^(14-i) is cw[i]
    function automatic logic [15:0] model(input logic [14:0][3:0] cw);
        logic [15:0] res;
        logic [3:0]  s;
        res = '0;
        for (int j = 0; j < 4; j++) begin
            s = 4'h0;
            for (int i = 0; i < 15; i++)
                s = s ^ gmul(cw[i], 4'(exp_t[((j + 1) * (14 - i)) % 15]));
            res[j*4 +: 4] = s;
        end
        return res;
    endfunction

    function automatic logic exp_err(input logic [15:0] syn);
`ifdef RS_SYN_ERR_FLAG_EN
        return |syn;
`else
        return 1'b0 & |syn;
`endif
    endfunction

    function automatic logic [15:0] dut_syn();
        return {bus.syndrome3, bus.syndrome2, bus.syndrome1, bus.syndrome0};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic send(input logic [3:0] d, input bit sof);
        bus.DIN       = d;
        bus.DIN_VALID = 1'b1;
        bus.SOF       = sof;
        @(negedge clk);
        bus.DIN_VALID = 1'b0;
        bus.SOF       = 1'b0;
    endtask

    task automatic send_cw(input string tag, input logic [14:0][3:0] cw,
                           input bit gaps, input logic [15:0] expv);
        int n;
        for (int i = 0; i < 15; i++) begin
            if (gaps && i > 0) begin
                n = $urandom_range(0, 2);
                repeat (n) begin
                    @(negedge clk);
                    chk({tag, " busy_in_gap"}, 16'(bus.BUSY), 16'h1);
                    chk({tag, " no_pulse_in_gap"}, 16'(bus.SYN_VALID), 16'h0);
                end
            end
            send(cw[i], i == 0);
            if (i < 14) begin
                chk({tag, " no_early_pulse"}, 16'(bus.SYN_VALID), 16'h0);
                chk({tag, " busy"}, 16'(bus.BUSY), 16'h1);
                chk({tag, " outputs_held"}, dut_syn(), cur_syn);
            end
        end
        chk({tag, " pulse"}, 16'(bus.SYN_VALID), 16'h1);
        chk({tag, " syndromes"}, dut_syn(), expv);
        chk({tag, " err_flag"}, 16'(bus.ERR_FLAG), 16'(exp_err(expv)));
        chk({tag, " not_busy_done"}, 16'(bus.BUSY), 16'h0);
        last_pulse = cyc;
        cur_syn    = expv;
    endtask

    initial begin
        logic [14:0][3:0] cw;
        logic [14:0][3:0] cw2;
        logic [15:0]      e2;
        int               p1;
        int               v;

        rst           = 1'b1;
        bus.DIN       = '0;
        bus.DIN_VALID = 1'b0;
        bus.SOF       = 1'b0;
        cur_syn       = '0;

        exp_t[0] = 1;
        log_t[0] = 0;
        log_t[1] = 0;
        for (int k = 1; k < 15; k++) begin
            v = exp_t[k-1] << 1;
            if (v >= 16) v = v ^ 19;
            exp_t[k] = v;
            log_t[v] = k;
        end

        tbl[0].name = "all_zero"; tbl[0].cw = '0; tbl[0].syn = 16'h0000;
        tbl[1].name = "r14_one";  tbl[1].cw = '0; tbl[1].cw[0]  = 4'h1; tbl[1].syn = 16'hEFD9;
        tbl[2].name = "r13_one";  tbl[2].cw = '0; tbl[2].cw[1]  = 4'h1; tbl[2].syn = 16'hBAED;
        tbl[3].name = "r0_one";   tbl[3].cw = '0; tbl[3].cw[14] = 4'h1; tbl[3].syn = 16'h1111;
        tbl[4].name = "r14_two";  tbl[4].cw = '0; tbl[4].cw[0]  = 4'h2; tbl[4].syn = 16'hFD91;

        repeat (2) @(negedge clk);
        chk("reset syndromes", dut_syn(), 16'h0);
        chk("reset syn_valid", 16'(bus.SYN_VALID), 16'h0);
        chk("reset err_flag", 16'(bus.ERR_FLAG), 16'h0);
        chk("reset busy", 16'(bus.BUSY), 16'h0);
        rst = 1'b0;
        @(negedge clk);

        // DIN_VALID without SOF in IDLE must be ignored
        send(4'hA, 1'b0);
        chk("idle_no_sof busy", 16'(bus.BUSY), 16'h0);

        for (int t = 0; t < 5; t++) begin
            send_cw(tbl[t].name, tbl[t].cw, 1'b0, tbl[t].syn);
            @(negedge clk);
            chk({tbl[t].name, " single_pulse"}, 16'(bus.SYN_VALID), 16'h0);
            chk({tbl[t].name, " held_after"}, dut_syn(), tbl[t].syn);
        end

        send_cw("r0_gaps", tbl[3].cw, 1'b1, 16'h1111);
        repeat (3) begin
            @(negedge clk);
            chk("r0_gaps no_second_pulse", 16'(bus.SYN_VALID), 16'h0);
        end

        // abort: six symbols, then SOF restarts with fifteen zeros
        send_cw("pre_abort", tbl[1].cw, 1'b0, 16'hEFD9);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            send(4'($urandom_range(1, 15)), i == 0);
            chk("abort partial no_pulse", 16'(bus.SYN_VALID), 16'h0);
            chk("abort partial held", dut_syn(), 16'hEFD9);
        end
        send_cw("abort_restart", '0, 1'b0, 16'h0000);

        // back-to-back: second SOF lands in the DONE cycle
        for (int i = 0; i < 15; i++) begin
            cw[i]  = 4'($urandom_range(0, 15));
            cw2[i] = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        send_cw("b2b_first", cw, 1'b0, model(cw));
        p1 = last_pulse;
        e2 = model(cw2);
        send_cw("b2b_second", cw2, 1'b0, e2);
        chk("b2b pulse_spacing", 16'(last_pulse - p1), 16'd15);

        // asynchronous reset in the middle of a codeword
        @(negedge clk);
        send_cw("pre_reset", tbl[1].cw, 1'b0, 16'hEFD9);
        for (int i = 0; i < 5; i++) send(4'($urandom_range(0, 15)), i == 0);
        #2 rst = 1'b1;
        #1;
        chk("async_reset syndromes", dut_syn(), 16'h0);
        chk("async_reset busy", 16'(bus.BUSY), 16'h0);
        chk("async_reset syn_valid", 16'(bus.SYN_VALID), 16'h0);
        chk("async_reset err_flag", 16'(bus.ERR_FLAG), 16'h0);
        cur_syn = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 15; i++) cw[i] = 4'($urandom_range(0, 15));
        send_cw("post_reset", cw, 1'b0, model(cw));

        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                send(4'($urandom_range(0, 15)), 1'b0);
                chk("rand idle_no_sof busy", 16'(bus.BUSY), 16'h0);
            end
            for (int i = 0; i < 15; i++) cw[i] = 4'($urandom_range(0, 15));
            send_cw("random", cw, bit'($urandom_range(0, 1)), model(cw));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
